// File: rtl/traffic_phase_scheduler_if.sv
// Junction sensor/lamp bundle: controller side uses the slave modport, sensor/lamp side the master.
// All lamp-side signals are registered inside the scheduler; no input feeds an output combinationally.
interface traffic_phase_scheduler_if;
  logic       tick;
  logic       sensor;
  logic       ped_req;
  logic [1:0] highway;
  logic [1:0] small_road;
  logic       ped_walk;
  logic       ped_pending;
  logic [2:0] phase;

  modport master (
    output tick, sensor, ped_req,
    input  highway, small_road, ped_walk, ped_pending, phase
  );

  modport slave (
    input  tick, sensor, ped_req,
    output highway, small_road, ped_walk, ped_pending, phase
  );
endinterface

// File: rtl/traffic_phase_scheduler.sv
// Tick-timed highway/side-road phase sequencer with latched pedestrian service.
// Outputs are registered from the next state, so lamps change on the same edge as the state.
module traffic_phase_scheduler #(
  parameter int CNT_W        = 8,
  parameter int HW_MIN_GREEN = 10,
  parameter int YEL_TIME     = 3,
  parameter int ALLRED_TIME  = 2,
  parameter int SR_MIN_GREEN = 4,
  parameter int SR_MAX_GREEN = 8
) (
  input  logic                     clk,
  input  logic                     clr_n,
  traffic_phase_scheduler_if.slave tps
);

  localparam logic [1:0] RED    = 2'd0;
  localparam logic [1:0] YELLOW = 2'd1;
  localparam logic [1:0] GREEN  = 2'd2;

  localparam logic [CNT_W-1:0] CNT_MAX    = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] HW_MIN_M1  = CNT_W'(HW_MIN_GREEN - 1);
  localparam logic [CNT_W-1:0] YEL_M1     = CNT_W'(YEL_TIME - 1);
  localparam logic [CNT_W-1:0] ALLRED_M1  = CNT_W'(ALLRED_TIME - 1);
  localparam logic [CNT_W-1:0] SR_MIN_M1  = CNT_W'(SR_MIN_GREEN - 1);
  localparam logic [CNT_W-1:0] SR_MAX_M1  = CNT_W'(SR_MAX_GREEN - 1);

  typedef enum logic [2:0] {
    HW_GRN = 3'd0,
    HW_YEL = 3'd1,
    AR1    = 3'd2,
    SR_GRN = 3'd3,
    SR_YEL = 3'd4,
    AR2    = 3'd5,
    BAD6   = 3'd6,
    BAD7   = 3'd7
  } state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               pend_q, pend_d;
  logic               walk_q, walk_d;
  logic [1:0]         hw_q, sr_q;
  logic [2:0]         phase_q;
  logic               sr_enter;
  logic               sr_exit;

  // Head encoding {highway, small_road} for a given state.
  function automatic logic [3:0] heads_of(input state_e s);
    case (s)
      HW_GRN:  heads_of = {GREEN,  RED};
      HW_YEL:  heads_of = {YELLOW, RED};
      SR_GRN:  heads_of = {RED,    GREEN};
      SR_YEL:  heads_of = {RED,    YELLOW};
      default: heads_of = {RED,    RED};
    endcase
  endfunction

  always_comb begin
    state_d = state_q;
    case (state_q)
      HW_GRN: if (tps.tick && cnt_q >= HW_MIN_M1 && (tps.sensor || pend_q)) state_d = HW_YEL;
      HW_YEL: if (tps.tick && cnt_q == YEL_M1)    state_d = AR1;
      AR1:    if (tps.tick && cnt_q == ALLRED_M1) state_d = SR_GRN;
      SR_GRN: if (tps.tick && (cnt_q == SR_MAX_M1 || (cnt_q >= SR_MIN_M1 && !tps.sensor)))
                state_d = SR_YEL;
      SR_YEL: if (tps.tick && cnt_q == YEL_M1)    state_d = AR2;
      AR2:    if (tps.tick && cnt_q == ALLRED_M1) state_d = HW_GRN;
      // Unreachable codes recover through a clearance phase, independent of tick.
      default: state_d = AR2;
    endcase
  end

  always_comb begin
    sr_enter = (state_q == AR1) && (state_d == SR_GRN);
    sr_exit  = (state_q == SR_GRN) && (state_d != SR_GRN);

    cnt_d = cnt_q;
    if (state_d != state_q) begin
      cnt_d = '0;
    end else if (tps.tick && cnt_q != CNT_MAX) begin
      cnt_d = cnt_q + 1'b1;
    end

    // A fresh press on the service edge must survive into the next cycle of phases.
    pend_d = pend_q;
    if (tps.ped_req) begin
      pend_d = 1'b1;
    end else if (sr_enter) begin
      pend_d = 1'b0;
    end

    walk_d = walk_q;
    if (sr_enter) begin
      walk_d = pend_q;
    end else if (sr_exit) begin
      walk_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state_q <= HW_GRN;
      cnt_q   <= '0;
      pend_q  <= 1'b0;
      walk_q  <= 1'b0;
      hw_q    <= GREEN;
      sr_q    <= RED;
      phase_q <= 3'd0;
    end else begin
      state_q          <= state_d;
      cnt_q            <= cnt_d;
      pend_q           <= pend_d;
      walk_q           <= walk_d;
      {hw_q, sr_q}     <= heads_of(state_d);
      phase_q          <= state_d;
    end
  end

  assign tps.highway     = hw_q;
  assign tps.small_road  = sr_q;
  assign tps.ped_walk    = walk_q;
  assign tps.ped_pending = pend_q;
  assign tps.phase       = phase_q;

endmodule

// File: tb/tb_traffic_phase_scheduler.sv
// Scoreboard bench: expected lamp/phase values per cycle are queued as stimulus is driven
// and compared on the following falling edge.
module tb_traffic_phase_scheduler;

  logic clk   = 1'b0;
  logic clr_n = 1'b1;
  always #5 clk = ~clk;

  traffic_phase_scheduler_if bus ();

  traffic_phase_scheduler dut (
    .clk   (clk),
    .clr_n (clr_n),
    .tps   (bus)
  );

  typedef struct packed {
    logic [1:0]  hw;
    logic [1:0]  sr;
    logic [2:0]  ph;
    logic        walk;
    logic        pend;
    logic [7:0]  sc;
    logic [15:0] cyc;
  } exp_t;

  exp_t sb_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // Phase code from the cumulative end cycles of each phase.
  function automatic int seq(input int n, input int e0, input int e1, input int e2,
                             input int e3, input int e4, input int e5);
    if (n < e0) return 0;
    if (n < e1) return 1;
    if (n < e2) return 2;
    if (n < e3) return 3;
    if (n < e4) return 4;
    if (n < e5) return 5;
    return 0;
  endfunction

  function automatic int phase_of(input int sc, input int n);
    case (sc)
      2:       return seq(n, 10, 13, 15, 23, 26, 28);
      3:       return seq(n, 41, 44, 46, 500, 500, 500);
      6:       return seq(n >> 2, 10, 13, 15, 23, 26, 28);
      7:       return seq(n, 10, 33, 35, 500, 500, 500);
      default: return seq(n, 10, 13, 15, 19, 22, 24);
    endcase
  endfunction

  function automatic logic [1:0] hw_of(input int ph);
    return (ph == 0) ? 2'd2 : (ph == 1) ? 2'd1 : 2'd0;
  endfunction

  function automatic logic [1:0] sr_of(input int ph);
    return (ph == 3) ? 2'd2 : (ph == 4) ? 2'd1 : 2'd0;
  endfunction

  function automatic logic sensor_of(input int sc, input int n);
    case (sc)
      3:       return (n == 3) || (n >= 40);
      5:       return n <= 16;
      1, 4:    return 1'b0;
      default: return 1'b1;
    endcase
  endfunction

  function automatic logic ped_of(input int sc, input int n);
    case (sc)
      1:       return (n == 2) || (n == 16);
      4:       return n == 2;
      5:       return n == 14;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic tick_of(input int sc, input int n);
    case (sc)
      6:       return (n % 4) == 3;
      7:       return !(n >= 12 && n <= 31);
      default: return 1'b1;
    endcase
  endfunction

  function automatic exp_t expect_of(input int sc, input int n);
    exp_t e;
    int   ph;
    ph    = phase_of(sc, n);
    e.ph  = 3'(ph);
    e.hw  = hw_of(ph);
    e.sr  = sr_of(ph);
    e.walk = (sc == 1 || sc == 4) && n >= 15 && n <= 18;
    e.pend = ((sc == 1 || sc == 4) && n >= 3 && n <= 14) || (sc == 5 && n >= 15);
    e.sc  = 8'(sc);
    e.cyc = 16'(n);
    return e;
  endfunction

  always @(negedge clk) begin
    if (sb_q.size() > 0) begin
      exp_t e;
      string t;
      e = sb_q.pop_front();
      t = $sformatf("s%0d_c%0d", e.sc, e.cyc);
      check_eq({t, "_hw"},   bus.highway,     e.hw);
      check_eq({t, "_sr"},   bus.small_road,  e.sr);
      check_eq({t, "_ph"},   bus.phase,       e.ph);
      check_eq({t, "_walk"}, bus.ped_walk,    e.walk);
      check_eq({t, "_pend"}, bus.ped_pending, e.pend);
    end
  end

  task automatic check_reset_vals(input string tag);
    check_eq({tag, "_hw"},   bus.highway,     2);
    check_eq({tag, "_sr"},   bus.small_road,  0);
    check_eq({tag, "_ph"},   bus.phase,       0);
    check_eq({tag, "_walk"}, bus.ped_walk,    0);
    check_eq({tag, "_pend"}, bus.ped_pending, 0);
  endtask

  // Leaves the bench just after an edge, so the next rising edge is cycle 0.
  task automatic do_reset();
    bus.tick    = 1'b0;
    bus.sensor  = 1'b0;
    bus.ped_req = 1'b0;
    clr_n = 1'b0;
    #1;
    check_reset_vals("rst");
    repeat (2) @(posedge clk);
    #1;
    clr_n = 1'b1;
  endtask

  task automatic run_scenario(input int sc, input int last);
    for (int n = 0; n <= last; n++) begin
      bus.tick    = tick_of(sc, n);
      bus.sensor  = sensor_of(sc, n);
      bus.ped_req = ped_of(sc, n);
      sb_q.push_back(expect_of(sc, n));
      @(posedge clk);
      #1;
    end
    bus.tick    = 1'b0;
    bus.sensor  = 1'b0;
    bus.ped_req = 1'b0;
  endtask

  initial begin
    bus.tick    = 1'b0;
    bus.sensor  = 1'b0;
    bus.ped_req = 1'b0;
    #2;

    do_reset(); run_scenario(2, 37);
    do_reset(); run_scenario(3, 44);
    do_reset(); run_scenario(4, 26);
    do_reset(); run_scenario(5, 26);
    do_reset(); run_scenario(6, 119);
    do_reset(); run_scenario(7, 35);

    // Mid side-road green with walk lit and a fresh request pending, then async reset.
    do_reset(); run_scenario(1, 16);
    check_eq("mid_ph",   bus.phase,       3);
    check_eq("mid_sr",   bus.small_road,  2);
    check_eq("mid_walk", bus.ped_walk,    1);
    check_eq("mid_pend", bus.ped_pending, 1);
    clr_n = 1'b0;
    #1;
    check_reset_vals("midrst");
    #3;
    clr_n = 1'b1;
    repeat (2) @(posedge clk);

    check_eq("sb_drained", sb_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
